// File: rtl/hdb3_desub.sv
// hdb3_desub: HDB3 de-substitution for the receive path.
// Takes per-rail symbol codes (00 space, 01 mark, 11 violation, 10 illegal),
// clears every V-terminated substitution (000V / B00V) back to 0000 through a
// four-symbol delay line, and flags code-rule errors.
// Optional statistics counters are enabled by defining HDB3_DESUB_STATS_EN.
module hdb3_desub
`ifdef HDB3_DESUB_STATS_EN
#(
    parameter int unsigned CNT_W = 16
)
`endif
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] code_p,
    input  logic [1:0] code_n,
    output logic       data_out,
    output logic       out_valid,
    output logic       err
`ifdef HDB3_DESUB_STATS_EN
    ,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] viol_cnt,
    output logic [CNT_W-1:0] err_cnt
`endif
);

    logic [3:0] sr_q, sr_d;
    logic [2:0] fill_q, fill_d;
    logic [1:0] gap_q, gap_d;
    logic       data_q, data_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;

    logic both_nz, illegal, mark, viol, e_gap, e_window;

    // Symbol decode; a malformed symbol is demoted to a plain mark.
    always_comb begin
        both_nz  = (code_p != 2'b00) && (code_n != 2'b00);
        illegal  = (code_p == 2'b10) || (code_n == 2'b10);
        mark     = (code_p != 2'b00) || (code_n != 2'b00);
        viol     = ((code_p == 2'b11) || (code_n == 2'b11)) && !both_nz && !illegal;
        e_gap    = viol && (gap_q != 2'd3);
        e_window = viol && (sr_q[1] || sr_q[0]);
    end

    // Next-state: delay line, fill/gap counters and registered outputs.
    always_comb begin
        sr_d    = sr_q;
        fill_d  = fill_q;
        gap_d   = gap_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (en) begin
            data_d  = sr_q[3];
            valid_d = (fill_q == 3'd4);
            err_d   = both_nz || illegal || e_gap || e_window;
            sr_d    = viol ? 4'b0000 : {sr_q[2:0], mark};
            fill_d  = (fill_q == 3'd4) ? 3'd4 : fill_q + 3'd1;
            gap_d   = viol ? 2'd0 : ((gap_q == 2'd3) ? 2'd3 : gap_q + 2'd1);
        end
    end

    // State registers; gap starts saturated so the first V is never a gap error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q    <= 4'b0000;
            fill_q  <= 3'd0;
            gap_q   <= 2'd3;
            data_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            fill_q  <= fill_d;
            gap_q   <= gap_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign data_out  = data_q;
    assign out_valid = valid_q;
    assign err       = err_q;

`ifdef HDB3_DESUB_STATS_EN
    logic [CNT_W-1:0] viol_cnt_q, viol_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Saturating counters; a clear wins over a same-cycle increment.
    always_comb begin
        viol_cnt_d = viol_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (cnt_clr) begin
            viol_cnt_d = '0;
            err_cnt_d  = '0;
        end else begin
            if (en && viol && (viol_cnt_q != '1))
                viol_cnt_d = viol_cnt_q + 1'b1;
            if (err_d && (err_cnt_q != '1))
                err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            viol_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            viol_cnt_q <= viol_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign viol_cnt = viol_cnt_q;
    assign err_cnt  = err_cnt_q;
`endif

endmodule

// File: tb/tb_hdb3_desub.sv
module tb_hdb3_desub;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] code_p, code_n;
  logic       data_out, out_valid, err;

  always #5 clk = ~clk;

`ifdef HDB3_DESUB_STATS_EN
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;
  logic          cnt_clr;
  logic [CW-1:0] viol_cnt, err_cnt;
  int            m_vcnt, m_ecnt;

  hdb3_desub #(.CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .code_p    (code_p),
    .code_n    (code_n),
    .data_out  (data_out),
    .out_valid (out_valid),
    .err       (err),
    .cnt_clr   (cnt_clr),
    .viol_cnt  (viol_cnt),
    .err_cnt   (err_cnt)
  );
`else
  hdb3_desub dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .code_p    (code_p),
    .code_n    (code_n),
    .data_out  (data_out),
    .out_valid (out_valid),
    .err       (err)
  );
`endif

  int n_tests = 0;
  int n_fail  = 0;

  bit   hist[$];
  int   lastv;
  int   acc;
  logic m_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    lastv  = -4;
    acc    = 0;
    m_data = 1'b0;
`ifdef HDB3_DESUB_STATS_EN
    m_vcnt = 0;
    m_ecnt = 0;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    #2;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_err",   {31'd0, err},       32'd0);
    check("rst_data",  {31'd0, data_out},  32'd0);
`ifdef HDB3_DESUB_STATS_EN
    check("rst_vcnt", {24'd0, viol_cnt}, 32'd0);
    check("rst_ecnt", {24'd0, err_cnt},  32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic step(input logic e, input logic [1:0] p, input logic [1:0] n);
    logic ev, eerr;
    bit   b, il, v, mk, p1, p2;
    int   j, gap;
    @(negedge clk);
    en = e; code_p = p; code_n = n;
    ev = 1'b0; eerr = 1'b0; v = 1'b0;
    if (e) begin
      j   = acc;
      b   = (p != 2'b00) && (n != 2'b00);
      il  = (p == 2'b10) || (n == 2'b10);
      mk  = (p != 2'b00) || (n != 2'b00);
      v   = ((p == 2'b11) || (n == 2'b11)) && !b && !il;
      gap = j - lastv - 1;
      if (gap > 3) gap = 3;
      p1  = (j >= 1) ? hist[j-1] : 1'b0;
      p2  = (j >= 2) ? hist[j-2] : 1'b0;
      eerr = b || il || (v && gap < 3) || (v && (p1 || p2));
      m_data = (j >= 4) ? hist[j-4] : 1'b0;
      ev     = (j >= 4);
      hist.push_back(mk);
      if (v) begin
        for (int k = j - 3; k <= j; k++)
          if (k >= 0) hist[k] = 1'b0;
        lastv = j;
      end
      acc++;
    end
`ifdef HDB3_DESUB_STATS_EN
    if (cnt_clr) begin
      m_vcnt = 0;
      m_ecnt = 0;
    end else begin
      if (v && m_vcnt < CMAX) m_vcnt++;
      if (eerr && m_ecnt < CMAX) m_ecnt++;
    end
`endif
    @(posedge clk);
    #1;
    check("out_valid", {31'd0, out_valid}, {31'd0, ev});
    check("err",       {31'd0, err},       {31'd0, eerr});
    check("data_out",  {31'd0, data_out},  {31'd0, m_data});
`ifdef HDB3_DESUB_STATS_EN
    check("viol_cnt", {24'd0, viol_cnt}, m_vcnt);
    check("err_cnt",  {24'd0, err_cnt},  m_ecnt);
`endif
  endtask

  task automatic rand_step();
    int r;
    logic [1:0] p, n;
    r = $urandom_range(0, 99);
    p = 2'b00; n = 2'b00;
    if (r < 50) begin
      p = 2'b00;
    end else if (r < 75) begin
      if ($urandom_range(0, 1) == 1) p = 2'b01; else n = 2'b01;
    end else if (r < 85) begin
      if ($urandom_range(0, 1) == 1) p = 2'b11; else n = 2'b11;
    end else if (r < 90) begin
      p = 2'b01; n = 2'b01;
    end else if (r < 95) begin
      if ($urandom_range(0, 1) == 1) p = 2'b10; else n = 2'b10;
    end else begin
      p = 2'($urandom_range(0, 3));
      n = 2'($urandom_range(0, 3));
    end
    step(($urandom_range(0, 4) != 0), p, n);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; code_p = 2'b00; code_n = 2'b00;
`ifdef HDB3_DESUB_STATS_EN
    cnt_clr = 1'b0;
`endif
    model_reset();
    #12;
    do_reset();

    repeat (8) step(1'b1, 2'b00, 2'b00);

    step(1'b1, 2'b01, 2'b00); step(1'b1, 2'b00, 2'b00);
    step(1'b1, 2'b00, 2'b01); step(1'b1, 2'b01, 2'b00);
    repeat (8) step(1'b1, 2'b00, 2'b00);

    step(1'b1, 2'b00, 2'b01); repeat (3) step(1'b1, 2'b00, 2'b00);
    step(1'b1, 2'b11, 2'b00); repeat (6) step(1'b1, 2'b00, 2'b00);

    repeat (2) begin
      step(1'b1, 2'b01, 2'b00); step(1'b1, 2'b00, 2'b00);
      step(1'b1, 2'b00, 2'b00); step(1'b1, 2'b11, 2'b00);
    end
    step(1'b1, 2'b00, 2'b00); step(1'b1, 2'b00, 2'b11);
    repeat (5) step(1'b1, 2'b00, 2'b00);

    step(1'b1, 2'b01, 2'b01); step(1'b1, 2'b10, 2'b00);
    repeat (5) step(1'b1, 2'b00, 2'b00);

    step(1'b1, 2'b01, 2'b00); repeat (3) step(1'b0, 2'b11, 2'b11);
    repeat (5) step(1'b1, 2'b00, 2'b00);

    repeat (3) step(1'b1, 2'b01, 2'b00);
    do_reset();
    repeat (6) step(1'b1, 2'b01, 2'b00);

    repeat (3000) rand_step();

`ifdef HDB3_DESUB_STATS_EN
    do_reset();
    repeat (300) begin
      repeat (3) step(1'b1, 2'b00, 2'b00);
      step(1'b1, 2'b11, 2'b00);
    end
    check("vcnt_sat", {24'd0, viol_cnt}, CMAX);
    repeat (3) step(1'b1, 2'b00, 2'b00);
    cnt_clr = 1'b1;
    step(1'b1, 2'b11, 2'b00);
    cnt_clr = 1'b0;
    check("vcnt_clr", {24'd0, viol_cnt}, 32'd0);
    repeat (300) step(1'b1, 2'b01, 2'b01);
    check("ecnt_sat", {24'd0, err_cnt}, CMAX);
    repeat (400) begin
      cnt_clr = ($urandom_range(0, 49) == 0);
      rand_step();
    end
    cnt_clr = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
